// File: rtl/audio_fifo.sv
// Audio sample buffer and 8 kHz playback pacer in the CLK_40 domain.
// Bytes are buffered, primed, and then emitted as signed 16-bit samples, one per audio_clk_en tick.
module audio_fifo #(
    parameter int DEPTH       = 512,
    parameter int LOW_WATER   = 128,
    parameter int PRIME_LEVEL = 256
) (
    input  logic                       CLK_40,
    input  logic                       reset_n,
    input  logic                       audio_clk_en,
    input  logic                       write_audio,
    input  logic [7:0]                 audio_byte,
    input  logic                       flush,
    output logic                       audio_req,
    output logic [15:0]                sample_out,
    output logic                       sample_valid,
    output logic                       playing,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic [15:0]                underrun_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] LOW_L   = LW'(LOW_WATER);
    localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] PRIMING = 2'd1;
    localparam logic [1:0] PLAYING = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    rd_data;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          pop;
    logic          underrun;
    logic          s1_valid;
    logic          s1_pop;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        full     = (fill_level == DEPTH_L);
        empty    = (fill_level == '0);
        wr_en    = write_audio && !flush && !full;
        pop      = audio_clk_en && !flush && (state == PLAYING) && !empty;
        underrun = audio_clk_en && !flush && (state == PLAYING) && empty;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (wr_en) state_next = PRIMING;
                PRIMING: if (fill_level >= PRIME_L) state_next = PLAYING;
                PLAYING: if (underrun) state_next = PRIMING;
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset so it maps onto block RAM; pointers and level define validity.
    always_ff @(posedge CLK_40) begin
        if (wr_en) begin
            mem[wr_ptr] <= audio_byte;
        end
        rd_data <= mem[rd_ptr];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_level     <= '0;
            state          <= EMPTY;
            playing        <= 1'b0;
            overflow       <= 1'b0;
            underrun_count <= '0;
            audio_req      <= 1'b1;
        end else begin
            state   <= state_next;
            playing <= (state_next == PLAYING);
            // Requests track the previous cycle's level; the flush cycle forces a one-cycle drop.
            audio_req <= flush ? 1'b0 : (fill_level <= LOW_L);

            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_level <= '0;
                overflow   <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (pop)   rd_ptr <= rd_ptr + AW'(1);
                case ({wr_en, pop})
                    2'b10:   fill_level <= fill_level + LW'(1);
                    2'b01:   fill_level <= fill_level - LW'(1);
                    default: fill_level <= fill_level;
                endcase
                if (write_audio && full) overflow <= 1'b1;
            end

            if (underrun && underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

    // Two-stage sample pipeline: RAM read, then format; every tick emits, popped or not.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s1_pop       <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
        end else begin
            s1_valid     <= audio_clk_en;
            s1_pop       <= pop;
            sample_valid <= s1_valid;
            if (s1_valid) begin
                sample_out <= (s1_pop && !flush) ? {rd_data ^ 8'h80, 8'h00} : 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_audio_fifo.sv
// Self-checking bench for audio_fifo: queue-based reference model plus a sample scoreboard.
// Directed scenarios cover priming, pacing, underrun, overflow/flush, and mid-pipeline reset; then random traffic.
module tb_audio_fifo;

    localparam int DEPTH       = 512;
    localparam int LOW_WATER   = 128;
    localparam int PRIME_LEVEL = 256;

    localparam int S_EMPTY = 0;
    localparam int S_PRIM  = 1;
    localparam int S_PLAY  = 2;

    logic        CLK_40 = 1'b0;
    logic        reset_n = 1'b0;
    logic        audio_clk_en = 1'b0;
    logic        write_audio = 1'b0;
    logic [7:0]  audio_byte = 8'h00;
    logic        flush = 1'b0;
    logic        audio_req;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        playing;
    logic [9:0]  fill_level;
    logic        overflow;
    logic [15:0] underrun_count;

    audio_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER), .PRIME_LEVEL(PRIME_LEVEL)) dut (
        .CLK_40         (CLK_40),
        .reset_n        (reset_n),
        .audio_clk_en   (audio_clk_en),
        .write_audio    (write_audio),
        .audio_byte     (audio_byte),
        .flush          (flush),
        .audio_req      (audio_req),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .playing        (playing),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .underrun_count (underrun_count)
    );

    always #5 CLK_40 = ~CLK_40;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffer contents as a queue, playback mode, and flags.
    logic [7:0]  m_q[$];
    logic [15:0] exp_q[$];
    int          m_st;
    bit          m_ovf;
    bit          m_areq;
    logic [15:0] m_urc;
    bit          m_prev_tick;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_st        = S_EMPTY;
        m_ovf       = 1'b0;
        m_areq      = 1'b1;
        m_urc       = 16'h0000;
        m_prev_tick = 1'b0;
    endtask

    task automatic model_step(input bit w, input logic [7:0] b, input bit t, input bit f);
        int sz0;
        int st0;
        logic [7:0] popped;
        sz0    = m_q.size();
        st0    = m_st;
        m_areq = f ? 1'b0 : (sz0 <= LOW_WATER);
        if (f) begin
            m_q.delete();
            m_st  = S_EMPTY;
            m_ovf = 1'b0;
            // A sample already in flight comes out silent.
            if (m_prev_tick && exp_q.size() > 0) exp_q[exp_q.size()-1] = 16'h0000;
            if (t) exp_q.push_back(16'h0000);
        end else begin
            if (t) begin
                if (st0 == S_PLAY && sz0 > 0) begin
                    popped = m_q.pop_front();
                    exp_q.push_back({popped ^ 8'h80, 8'h00});
                end else begin
                    exp_q.push_back(16'h0000);
                    if (st0 == S_PLAY) begin
                        if (m_urc != 16'hFFFF) m_urc = m_urc + 16'd1;
                        m_st = S_PRIM;
                    end
                end
            end
            if (w) begin
                if (sz0 < DEPTH) begin
                    m_q.push_back(b);
                    if (st0 == S_EMPTY) m_st = S_PRIM;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (st0 == S_PRIM && sz0 >= PRIME_LEVEL) m_st = S_PLAY;
        end
        m_prev_tick = t;
    endtask

    task automatic check_model();
        check("fill_level", 32'(fill_level), 32'(m_q.size()));
        check("playing", 32'(playing), 32'(m_st == S_PLAY));
        check("audio_req", 32'(audio_req), 32'(m_areq));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underrun_count", 32'(underrun_count), 32'(m_urc));
    endtask

    task automatic cycle(input bit w, input logic [7:0] b, input bit t, input bit f);
        write_audio  = w;
        audio_byte   = b;
        audio_clk_en = t;
        flush        = f;
        model_step(w, b, t, f);
        @(posedge CLK_40);
        #1;
        write_audio  = 1'b0;
        audio_clk_en = 1'b0;
        flush        = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every sample_valid pulse must match the oldest expected sample.
    logic [15:0] mon_exp;
    always @(negedge CLK_40) begin
        if (reset_n && sample_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sample_valid: got sample 0x%0h, expected no pulse at %0t", sample_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sample_out", 32'(sample_out), 32'(mon_exp));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK_40);
        #1;
        check_model();
        check("reset_sample_out", 32'(sample_out), 32'h0);
        check("reset_sample_valid", 32'(sample_valid), 32'h0);
        reset_n = 1'b1;

        // Prime with 0x00..0xFF; playback starts the cycle after the level reaches PRIME_LEVEL.
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check("primed_level", 32'(fill_level), 32'd256);
        check("primed_not_yet_playing", 32'(playing), 32'd0);
        idle(1);
        check("playing_rises", 32'(playing), 32'd1);
        check("req_dropped", 32'(audio_req), 32'd0);

        // Paced playback: expect 0x8000, 0x8100, ... 0x7F00 via the scoreboard.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            idle(19);
        end
        check("drained_level", 32'(fill_level), 32'd0);

        // 257th tick with an empty buffer is an underrun.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);
        check("underrun_count_one", 32'(underrun_count), 32'd1);
        check("underrun_not_playing", 32'(playing), 32'd0);
        check("underrun_req", 32'(audio_req), 32'd1);

        // Fill to capacity, then one extra write is dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("full_level", 32'(fill_level), 32'd512);
        check("overflow_set", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_level", 32'(fill_level), 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_not_playing", 32'(playing), 32'd0);
        idle(2);

        // Simultaneous write and pop at level 300 keeps the level and pops the oldest byte.
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(2);
        check("level_300_playing", 32'(playing), 32'd1);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        check("write_pop_level", 32'(fill_level), 32'd300);
        idle(3);

        // Reset between a tick and its sample_valid.
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model();
        check("midrst_sample_out", 32'(sample_out), 32'h0);
        check("midrst_sample_valid", 32'(sample_valid), 32'h0);
        @(negedge CLK_40);
        check("midrst_no_pulse", 32'(sample_valid), 32'h0);
        @(posedge CLK_40);
        #1;
        reset_n = 1'b1;
        idle(3);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) == 0));
        end
        idle(4);
        check("sample_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_fifo.md
Name: audio_fifo

Overview:
Audio sample buffer and playback pacer sitting between the SPI data-acquisition FSM (producer of audio bytes) and the audio codec interface (consumer of paced samples).
- Stores 8-bit unsigned PCM bytes arriving in bursts from the SD/SPI path.
- Primes before playback, then emits one 16-bit signed sample per 8 kHz audio_clk_en tick.
- Raises a refill request to the acquisition FSM when the buffer runs low.
- Runs entirely in the CLK_40 domain using clock enables; no second clock.

Parameters:
DEPTH, 512, FIFO capacity in bytes; power of two, 16..4096.
LOW_WATER, 128, audio_req asserts when fill_level <= LOW_WATER.
PRIME_LEVEL, 256, bytes required before playback (re)starts; must satisfy LOW_WATER < PRIME_LEVEL <= DEPTH.

Ports:
CLK_40  input  1  system clock, 40 MHz.
reset_n  input  1  asynchronous active-low reset.
audio_clk_en  input  1  single-cycle 8 kHz sample tick.
write_audio  input  1  single-cycle strobe; audio_byte valid.
audio_byte  input  8  unsigned PCM byte, 0x80 = silence.
flush  input  1  single-cycle; empties buffer, returns to EMPTY.
audio_req  output  1  refill request to the acquisition FSM.
sample_out  output  16  signed sample to codec, held between ticks.
sample_valid  output  1  single-cycle pulse per emitted sample.
playing  output  1  high in PLAYING state.
fill_level  output  clog2(DEPTH)+1  bytes currently stored.
overflow  output  1  sticky: a write arrived while full.
underrun_count  output  16  saturating count of underrun events.

Behaviour:
- Reset values (async on reset_n low): pointers 0, fill_level 0, state EMPTY, sample_out 0, sample_valid 0, playing 0, overflow 0, underrun_count 0, audio_req 1.
- Storage: inferred synchronous RAM, one-cycle read latency. Write and read pointers have clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Write: write_audio while fill_level < DEPTH stores the byte and increments the level. Write while full drops the byte and sets overflow.
- States:
  - EMPTY: entered from reset or flush. First accepted write -> PRIMING.
  - PRIMING: -> PLAYING in the cycle after fill_level >= PRIME_LEVEL.
  - PLAYING: each audio_clk_en pops one byte. A tick with fill_level == 0 is an underrun: underrun_count +1 (saturates at 0xFFFF), state -> PRIMING.
- Sample path, tick at cycle T:
  - sample_valid pulses at T+2 on every tick, regardless of state, so the codec sees a constant rate.
  - Pop in PLAYING: sample_out = {audio_byte ^ 8'h80, 8'h00}.
  - Otherwise (EMPTY, PRIMING, or underrun): sample_out = 16'h0000.
  - sample_out holds its value until the next emission.
- Simultaneous write and pop in the same cycle: both occur and fill_level is unchanged. A pop never reads the byte being written in that same cycle; when the level is 0 it counts as an underrun.
- flush has priority over write and tick in the same cycle:
  - pointers and level go to 0, state -> EMPTY, overflow clears;
  - underrun_count is retained;
  - any pipelined sample still emits at T+2 as 0.
- audio_req is registered: 1 when fill_level <= LOW_WATER, updated one cycle after the level change. It is forced 0 during the flush cycle and 1 thereafter if empty.
- playing equals (state == PLAYING), registered.
- reset_n asserted mid-operation: all state clears immediately. No sample_valid pulse until a tick occurs after reset is released.

Test Plan:
- Reset, then 256 writes of 0x00..0xFF with no ticks -> fill_level=256, playing rises the cycle after the 256th write, audio_req drops once level exceeds 128.
- Continue with ticks every 5000 cycles -> sample_valid pulse 2 cycles after each tick; sample_out sequence 0x8000, 0x8100, ..., 0x7F00 for bytes 0x00..0xFF; fill_level decrements per tick.
- Prime with 256 bytes, then tick 257 times with no writes -> final tick yields sample_out=0x0000, underrun_count=1, playing=0, audio_req=1.
- Fill to 512, write 0xAA -> byte dropped, fill_level stays 512, overflow=1. Assert flush -> fill_level=0, overflow=0, state EMPTY.
- write_audio and audio_clk_en in the same cycle at level 300 while PLAYING -> level remains 300; the popped sample is the oldest byte.
- Assert reset_n low mid-playback, between a tick and its sample_valid -> no sample_valid pulse; all outputs at reset values within the same cycle.
